// File: rtl/reg_feeder.sv
// reg_feeder: FIFO-buffered feeder that loads a register one word at a time with a programmable hold gap.
// Optional readback check: define REG_FEEDER_CHECK_EN to compare reg_q against each loaded word.
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_data is the offered word
//   reg_en, reg_d        register load enable (one-cycle pulse) and data
//   reg_q                register output used for the readback check
//   count                FIFO occupancy (0..DEPTH)
//   busy                 FSM not idle or FIFO non-empty
//   err_flag, err_cnt    sticky mismatch flag and saturating mismatch count (0 when check disabled)
module reg_feeder #(
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DWIDTH-1:0]        in_data,
    output logic                     reg_en,
    output logic [DWIDTH-1:0]        reg_d,
    input  logic [DWIDTH-1:0]        reg_q,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     err_flag,
    output logic [15:0]              err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [HW-1:0] HOLD_INIT = HOLD_CYCLES[HW-1:0];

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t            state, state_nx;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic              push, pop;

    assign in_ready = count != FULL;
    assign push     = in_valid && in_ready;
    // pop uses the registered count, so a word is never loaded on the edge it arrives
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE) || (count != '0);

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: state_nx = pop ? LOAD : IDLE;
            LOAD: begin
                hold_nx  = HOLD_INIT;
                state_nx = (HOLD_CYCLES > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                hold_nx  = hold_cnt - 1'b1;
                state_nx = (hold_cnt == HW'(1)) ? IDLE : HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            reg_en   <= 1'b0;
            reg_d    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            reg_en   <= pop;
            if (pop) begin
                reg_d  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef REG_FEEDER_CHECK_EN
    logic chk;

    // chk marks the cycle after LOAD; reg_d still holds the loaded word then, even with no hold gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk      <= 1'b0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            chk <= state == LOAD;
            if (chk && reg_q != reg_d) begin
                err_flag <= 1'b1;
                err_cnt  <= err_cnt + 16'(err_cnt != 16'hFFFF);
            end
        end
    end
`else
    logic unused_q;

    assign unused_q = ^reg_q;
    assign err_flag = 1'b0;
    assign err_cnt  = '0;
`endif
endmodule

// File: doc/reg_feeder.md
Name: reg_feeder

Overview:
- Upstream stage for the general register block.
- Accepts data words over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register's load-enable and data input one word at a time, holding each loaded value for a programmable number of cycles so downstream logic and the bench can observe it.
- Sits between the stimulus/bus side and the register wrapper, connecting to the register's enable/data/q signals.

Parameters:
- DWIDTH, 8: data width; matches the register width.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 2: idle cycles after each load before the next load; 0 allowed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  DWIDTH  upstream word.
- reg_en  output  1  register load enable.
- reg_d  output  DWIDTH  register data input.
- reg_q  input  DWIDTH  register output, used for readback check.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
- err_flag  output  1  sticky readback mismatch (see Optional Feature).
- err_cnt  output  16  saturating mismatch counter (see Optional Feature).

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n=0, all state clears immediately:
  - FIFO empty, count=0, in_ready=1;
  - reg_en=0, reg_d=0;
  - busy=0, err_flag=0, err_cnt=0;
  - FSM=IDLE.
- Reset mid-operation discards all buffered words; no load is issued after release until a new push.
- Push: occurs on a rising edge with in_valid=1 and in_ready=1. in_ready = (count != DEPTH), combinational from count.
- No bypass: a word pushed at edge N is loaded no earlier than edge N+1.
- Pop and push on the same edge: count is unchanged; pointers wrap modulo DEPTH.
- FSM, all outputs registered:
  - IDLE: if count>0 -> LOAD. At this edge: reg_en<=1, reg_d<=FIFO head, pop.
  - LOAD: reg_en is high for exactly one cycle. Next edge: reg_en<=0, hold counter<=HOLD_CYCLES; next state is HOLD if HOLD_CYCLES>0, else IDLE.
  - HOLD: counter decrements each edge; at counter==1 -> IDLE.
  - reg_d retains the last loaded value outside LOAD.
- Throughput: one load per (2+HOLD_CYCLES) cycles when the FIFO is never empty.
- Latency from push (edge N, FIFO previously empty, FSM IDLE) to register capture: edge N+2.
- Full FIFO: in_ready=0; in_valid is ignored and the word is not stored. Upstream must hold data.
- Empty FIFO in IDLE: reg_en stays 0; busy=0.
- count is exact at every edge and never exceeds DEPTH.

Optional Feature:
- Macro: REG_FEEDER_CHECK_EN.
- Defined:
  - On the first cycle after LOAD, the value loaded (stored internally) is compared with reg_q, sampled at the edge ending that cycle.
  - Mismatch sets err_flag (sticky until reset) and increments err_cnt, which saturates at 16'hFFFF.
  - The check runs regardless of HOLD_CYCLES, including 0.
- Not defined: err_flag and err_cnt are tied to 0; no compare logic is synthesised. The ports remain present so the interface is identical.

Test Plan:
- Reset then single push 8'hA5 at edge N -> reg_en=1 only in cycle N+1..N+2, reg_d=8'hA5; count returns to 0; busy drops after HOLD completes.
- With DEPTH=4 and 6 back-to-back pushes (0x01..0x06) with valid held -> in_ready falls when count=4; loads appear in order 0x01..0x06, spaced 4 cycles apart (HOLD_CYCLES=2); no word lost or duplicated.
- With HOLD_CYCLES=0 and continuous input -> reg_en pulses every 2nd cycle; push and pop on the same edge keep count constant.
- Assert rst_n=0 asynchronously mid-HOLD with 3 words buffered -> outputs clear immediately without a clock edge; after release, no reg_en pulse until a new push.
- REG_FEEDER_CHECK_EN defined, bench forces reg_q=8'h00 after a load of 8'h3C -> err_flag=1, err_cnt=1; a correct load of 8'h11 next -> err_cnt stays 1, err_flag stays 1.
- REG_FEEDER_CHECK_EN undefined, same stimulus -> err_flag=0, err_cnt=0.
